// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared state encoding and constants for the RC4 engine.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    localparam int S_SIZE = 256;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_KSA_RD_I  = 4'd2,
        ST_KSA_RD_J  = 4'd3,
        ST_KSA_WR    = 4'd4,
        ST_PRGA_RD_I = 4'd5,
        ST_PRGA_RD_J = 4'd6,
        ST_PRGA_WR   = 4'd7,
        ST_PRGA_RD_F = 4'd8,
        ST_PRGA_OUT  = 4'd9,
        ST_DONE      = 4'd10
    } state_t;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_char_valid.sv
`default_nettype none
// ============================================================================
// Module      : rc4_char_valid
// Description : Flags a byte as a lower-case ASCII letter or a space.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_char_valid
    import rc4_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_valid
);

    assign o_valid = ((i_char >= CHAR_LO) && (i_char <= CHAR_HI)) || (i_char == CHAR_SP);

endmodule : rc4_char_valid
`default_nettype wire

// File: rtl/rc4_engine.sv
`default_nettype none
// ============================================================================
// Module      : rc4_engine
// Description : RC4 key schedule and keystream decrypt against external RAMs.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int CHECK_EN  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             enc_addr,
    input  logic [7:0]             enc_rdata,
    output logic [7:0]             dec_addr,
    output logic [7:0]             dec_wdata,
    output logic                   dec_wren
);

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_k;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [7:0]             r_f;
    logic                   r_ph;
    logic                   r_pass;
    logic [4:0]             r_kidx;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             w_key_byte;
    logic [7:0]             w_dec_data;
    logic                   w_valid;
    logic                   w_last_k;
    logic                   w_abort;

    assign w_dec_data = r_f ^ enc_rdata;
    assign w_last_k   = (r_k == 8'(MSG_LEN - 1));
    assign w_abort    = (CHECK_EN != 0) && !w_valid;
    assign pass       = r_pass;

    rc4_char_valid u_char_valid (
        .i_char  (w_dec_data),
        .o_valid (w_valid)
    );

    // r_kidx tracks i mod KEY_BYTES so no divider is needed.
    always_comb begin
        w_key_byte = r_key[8*KEY_BYTES-1 -: 8];
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_kidx == 5'(b)) begin
                w_key_byte = r_key[8*(KEY_BYTES-b)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Two-cycle states use r_ph as a sub-step; it is always 0 on entry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_INIT;
            ST_INIT:          if (r_i == 8'(S_SIZE - 1)) w_next = ST_KSA_RD_I;
            ST_KSA_RD_I:      w_next = ST_KSA_RD_J;
            ST_KSA_RD_J:      if (r_ph) w_next = ST_KSA_WR;
            ST_KSA_WR:        if (r_ph) w_next = (r_i == 8'hFF) ? ST_PRGA_RD_I : ST_KSA_RD_I;
            ST_PRGA_RD_I:     w_next = ST_PRGA_RD_J;
            ST_PRGA_RD_J:     if (r_ph) w_next = ST_PRGA_WR;
            ST_PRGA_WR:       if (r_ph) w_next = ST_PRGA_RD_F;
            ST_PRGA_RD_F:     if (r_ph) w_next = ST_PRGA_OUT;
            ST_PRGA_OUT:      w_next = (w_abort || w_last_k) ? ST_DONE : ST_PRGA_RD_I;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_k    <= 8'd0;
            r_si   <= 8'd0;
            r_sj   <= 8'd0;
            r_f    <= 8'd0;
            r_ph   <= 1'b0;
            r_pass <= 1'b0;
            r_kidx <= 5'd0;
            r_key  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_key  <= key;
                        r_i    <= 8'd0;
                        r_j    <= 8'd0;
                        r_k    <= 8'd0;
                        r_ph   <= 1'b0;
                        r_pass <= 1'b0;
                        r_kidx <= 5'd0;
                    end
                end
                ST_INIT: r_i <= r_i + 8'd1;
                ST_KSA_RD_J: begin
                    r_ph <= ~r_ph;
                    if (!r_ph) begin
                        r_si <= s_rdata;
                        r_j  <= r_j + s_rdata + w_key_byte;
                    end
                end
                ST_KSA_WR: begin
                    r_ph <= ~r_ph;
                    if (!r_ph) begin
                        r_sj <= s_rdata;
                    end else begin
                        r_i    <= r_i + 8'd1;
                        r_kidx <= (r_kidx == 5'(KEY_BYTES - 1)) ? 5'd0 : r_kidx + 5'd1;
                        if (r_i == 8'hFF) r_j <= 8'd0;
                    end
                end
                ST_PRGA_RD_I: r_i <= r_i + 8'd1;
                ST_PRGA_RD_J: begin
                    r_ph <= ~r_ph;
                    if (!r_ph) begin
                        r_si <= s_rdata;
                        r_j  <= r_j + s_rdata;
                    end
                end
                ST_PRGA_WR: begin
                    r_ph <= ~r_ph;
                    if (!r_ph) r_sj <= s_rdata;
                end
                ST_PRGA_RD_F: begin
                    r_ph <= ~r_ph;
                    if (r_ph) r_f <= s_rdata;
                end
                ST_PRGA_OUT: begin
                    if (w_abort)       r_pass <= 1'b0;
                    else if (w_last_k) r_pass <= 1'b1;
                    else               r_k    <= r_k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done      = (r_state == ST_DONE);
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        enc_addr  = 8'd0;
        dec_addr  = 8'd0;
        dec_wdata = 8'd0;
        dec_wren  = 1'b0;
        case (r_state)
            ST_INIT: begin
                s_wren  = 1'b1;
                s_addr  = r_i;
                s_wdata = r_i;
            end
            ST_KSA_RD_I:               s_addr = r_i;
            ST_PRGA_RD_I:              s_addr = r_i + 8'd1;
            ST_KSA_RD_J, ST_PRGA_RD_J: if (r_ph) s_addr = r_j;
            // First write stores old S[j] straight off the read port, second stores old S[i].
            ST_KSA_WR, ST_PRGA_WR: begin
                s_wren = 1'b1;
                if (!r_ph) begin
                    s_addr  = r_i;
                    s_wdata = s_rdata;
                end else begin
                    s_addr  = r_j;
                    s_wdata = r_si;
                end
            end
            ST_PRGA_RD_F: begin
                if (!r_ph) s_addr = r_si + r_sj;
                enc_addr = r_k;
            end
            ST_PRGA_OUT: begin
                enc_addr  = r_k;
                dec_wren  = 1'b1;
                dec_addr  = r_k;
                dec_wdata = w_dec_data;
            end
            default: ;
        endcase
    end

endmodule : rc4_engine
`default_nettype wire
